ac_ctrl: RTL

Sequencer for the accumulator stage of one neuron. It takes a start command with an input count and clears the accumulator. It then gates each product from the multiplier stage into the accumulator as a single `mu_rdy` pulse, counts the accumulated terms, and captures the final sum with a sticky overflow flag. The result is held on a valid/ready handshake to the activation/output stage, so the multiplier, accumulator and downstream logic are sequenced per neuron evaluation.

---
 rtl/ac_ctrl_pkg.sv | 13 +
 rtl/ac_ctrl_cnt.sv | 30 +++
 rtl/ac_ctrl.sv | 101 ++++++++++
 3 files changed

// File: rtl/ac_ctrl_pkg.sv
// Shared definitions for the neuron accumulator sequencer: data-bus width and FSM encoding.
package ac_ctrl_pkg;
  localparam int WORD_W = 16;
  localparam int ST_W   = 3;

  typedef enum logic [ST_W-1:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_RUN   = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_e;
endpackage

// File: rtl/ac_ctrl_cnt.sv
// Loadable down-counter tracking products still to be accumulated for one neuron.
module ac_ctrl_cnt #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             last,
  output logic             zero
);
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load)
      cnt_d = load_val;
    else if (dec && (cnt_q != '0))
      cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign last = (cnt_q == CNT_W'(1));
  assign zero = (cnt_q == '0);
endmodule

// File: rtl/ac_ctrl.sv
// Accumulator-stage sequencer: clear, gate CNT products into the accumulator, capture
// the sum with a sticky overflow and hold it on a valid/ready handshake.
module ac_ctrl
  import ac_ctrl_pkg::*;
#(
  parameter int CNT_W = 8,
  parameter int W     = WORD_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [CNT_W-1:0] n_terms,
  output logic             busy,
  input  logic             prod_valid,
  output logic             prod_ready,
  output logic             acc_clr,
  output logic             mu_rdy,
  input  logic             ac_rdy,
  input  logic [W-1:0]     ac_out,
  input  logic             off,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [W-1:0]     res_data,
  output logic             res_ovf
);
  state_e         state_q, state_d;
  logic           busy_q, busy_d;
  logic           acc_clr_q, acc_clr_d;
  logic           res_valid_q, res_valid_d;
  logic [W-1:0]   res_data_q, res_data_d;
  logic           res_ovf_q, res_ovf_d;
  logic           cnt_load, cnt_last, cnt_zero;

  ac_ctrl_cnt #(.CNT_W(CNT_W)) u_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load),
    .load_val (n_terms),
    .dec      (mu_rdy),
    .last     (cnt_last),
    .zero     (cnt_zero)
  );

  always_comb begin
    state_d    = state_q;
    res_data_d = res_data_q;
    res_ovf_d  = res_ovf_q;
    cnt_load   = 1'b0;
    prod_ready = 1'b0;
    case (state_q)
      ST_IDLE: if (start) begin
        cnt_load   = 1'b1;
        res_data_d = '0;
        res_ovf_d  = 1'b0;
        state_d    = ST_CLEAR;
      end
      ST_CLEAR: state_d = cnt_zero ? ST_DONE : ST_RUN;
      ST_RUN: begin
        prod_ready = 1'b1;
        if (prod_valid && cnt_last) state_d = ST_DRAIN;
      end
      ST_DRAIN: if (ac_rdy) begin
        res_data_d = ac_out;
        state_d    = ST_DONE;
      end
      ST_DONE: if (res_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    // Overflow of every add, including the one landing in DRAIN, is sticky.
    if ((state_q == ST_RUN || state_q == ST_DRAIN) && ac_rdy && off)
      res_ovf_d = 1'b1;
    mu_rdy      = prod_valid & prod_ready;
    busy_d      = (state_d != ST_IDLE);
    acc_clr_d   = (state_d == ST_CLEAR);
    res_valid_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      busy_q      <= 1'b0;
      acc_clr_q   <= 1'b0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_ovf_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      busy_q      <= busy_d;
      acc_clr_q   <= acc_clr_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_ovf_q   <= res_ovf_d;
    end
  end

  assign busy      = busy_q;
  assign acc_clr   = acc_clr_q;
  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign res_ovf   = res_ovf_q;
endmodule
